// File: rtl/data_sync_hs_if.sv
// data_sync_hs_if: source-side request/data and destination-side
// captured data, strobe, acknowledge and busy for one crossing.
interface data_sync_hs_if #(
   parameter int BUS_WIDTH = 8
);
   logic                 req_async;
   logic [BUS_WIDTH-1:0] unsync_bus;
   logic [BUS_WIDTH-1:0] sync_bus;
   logic                 enable_pulse;
   logic                 ack;
   logic                 busy;

   modport master (
      output req_async,
      output unsync_bus,
      input  sync_bus,
      input  enable_pulse,
      input  ack,
      input  busy
   );

   modport slave (
      input  req_async,
      input  unsync_bus,
      output sync_bus,
      output enable_pulse,
      output ack,
      output busy
   );
endinterface

// File: rtl/data_sync_hs.sv
// data_sync_hs: destination side of a 4-phase req/ack crossing.
// Synchronizes req, captures the held source bus, strobes, returns ack.
module data_sync_hs #(
   parameter int BUS_WIDTH  = 8,
   parameter int NUM_STAGES = 2
) (
   input logic           clk,
   input logic           rst,
   data_sync_hs_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CAPTURE  = 2'd1,
      WAIT_LOW = 2'd2
   } state_t;

   if (NUM_STAGES < 2 || NUM_STAGES > 4) begin : g_bad_stages
      $error("data_sync_hs: NUM_STAGES must be in 2..4");
   end

   logic [NUM_STAGES-1:0] sync_q;
   logic                  req_sync;
   state_t                state_q;
   state_t                state_d;
   logic [BUS_WIDTH-1:0]  data_q;
   logic [BUS_WIDTH-1:0]  data_d;
   logic                  en_q;
   logic                  en_d;
   logic                  ack_q;
   logic                  ack_d;
   logic                  busy_q;
   logic                  busy_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[NUM_STAGES-2:0], bus.req_async};
      end
   end

   assign req_sync = sync_q[NUM_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         en_q    <= 1'b0;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         en_q    <= en_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
      end
   end

   // The source bus is only looked at on the IDLE->CAPTURE edge
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      en_d    = 1'b0;
      ack_d   = ack_q;
      busy_d  = busy_q;
      unique case (state_q)
         IDLE: begin
            if (req_sync) begin
               state_d = CAPTURE;
               data_d  = bus.unsync_bus;
               en_d    = 1'b1;
               ack_d   = 1'b1;
               busy_d  = 1'b1;
            end
         end
         CAPTURE: begin
            state_d = WAIT_LOW;
         end
         WAIT_LOW: begin
            if (!req_sync) begin
               state_d = IDLE;
               ack_d   = 1'b0;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            ack_d   = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign bus.sync_bus     = data_q;
   assign bus.enable_pulse = en_q;
   assign bus.ack          = ack_q;
   assign bus.busy         = busy_q;
endmodule

// File: doc/data_sync_hs.md
# data_sync_hs

Destination-side controller for a 4-phase REQ/ACK bus handshake across a clock-domain crossing. It runs a multi-flop synchronizer on the incoming request level and captures the quasi-static source bus only once that request is stable. It then issues a one-cycle enable pulse to destination logic and drives ACK back to the source. The block sits at the receive edge of every multi-bit crossing (register-file config buses, UART RX data into the system clock domain) and pairs with a source-side ACK synchronizer.

## Interface
- BUS_WIDTH, 8, width of data bus carried across.
- NUM_STAGES, 2, flops in the REQ synchronizer chain; legal range 2..4. Values below 2 are illegal and trigger an elaboration-time error.
- CLK  input  1  destination-domain clock; all state updates on the rising edge.
- RST  input  1  reset, asynchronous and active-high. Clears all flops immediately.
- REQ_ASYNC  input  1  source request level, asynchronous to CLK.
- UNSYNC_BUS  input  BUS_WIDTH  source data. Held stable by the source from REQ_ASYNC rise until the source sees ACK high.
- SYNC_BUS  output  BUS_WIDTH  captured data, registered; holds the last captured value.
- ENABLE_PULSE  output  1  one-cycle strobe marking a new SYNC_BUS value, registered.
- ACK  output  1  acknowledge level to source domain, registered (driven straight from a flop, no logic after it).
- BUSY  output  1  high whenever the FSM is not in IDLE.

## Operation
- REQ_ASYNC passes through NUM_STAGES cascaded flops, all reset to 0. The last stage output is req_sync. Only req_sync is used by the FSM.
- UNSYNC_BUS is never used by any flop other than the SYNC_BUS capture register. It is sampled only on the capture edge.
- FSM states:
  - IDLE: ACK=0, BUSY=0. If req_sync=1, go to CAPTURE.
  - CAPTURE: lasts exactly one cycle, then go to WAIT_LOW.
  - WAIT_LOW: ACK=1, BUSY=1. If req_sync=0, go to IDLE.
- Edge entering CAPTURE (IDLE with req_sync=1):
  - SYNC_BUS <= UNSYNC_BUS.
  - ENABLE_PULSE <= 1.
  - ACK <= 1.
  - BUSY <= 1.
- Edge leaving CAPTURE: ENABLE_PULSE <= 0. ACK stays 1.
- Edge leaving WAIT_LOW (req_sync=0): ACK <= 0, BUSY <= 0.
- Exactly one ENABLE_PULSE per REQ_ASYNC high phase, however long REQ_ASYNC is held high.
- A REQ_ASYNC low phase that is too short to reach req_sync is invisible. No second transfer occurs.
- SYNC_BUS changes only on capture edges. Otherwise it holds its value indefinitely.
- Reset values: SYNC_BUS=0, ENABLE_PULSE=0, ACK=0, BUSY=0, state IDLE, synchronizer chain all 0.
- Reset mid-transfer: all outputs return to reset values asynchronously. Any pulse in flight is lost.
  - If REQ_ASYNC is still high after release, the chain refills and a new capture occurs.
  - The source therefore sees ACK fall and then rise again. This re-delivery is the required behaviour.
- RST released while REQ_ASYNC=1: first capture happens NUM_STAGES+1 edges after release. Outputs stay 0 until then.

## Timing
- Let edge k be the first CLK edge at which stage 1 samples REQ_ASYNC=1.
- req_sync is high after edge k+NUM_STAGES-1.
- Edge k+NUM_STAGES: SYNC_BUS valid, ENABLE_PULSE=1, ACK=1.
- Edge k+NUM_STAGES+1: ENABLE_PULSE=0.
- REQ-to-capture latency: NUM_STAGES+1 edges (3 with default), counting from the edge where stage 1 samples REQ_ASYNC=1.
- Let edge m be the first edge sampling REQ_ASYNC=0 while in WAIT_LOW (or CAPTURE). ACK=0 at edge m+NUM_STAGES.
- REQ_ASYNC falling during CAPTURE: the transfer completes normally. WAIT_LOW then sees req_sync=0, and ACK drops at edge m+NUM_STAGES.
- Minimum spacing between consecutive ENABLE_PULSEs: NUM_STAGES+2 cycles. This covers the drop, the IDLE entry, and the refill of a new high level.
- ENABLE_PULSE width: exactly 1 CLK cycle, never 0 and never 2.

## Test plan
- Basic transfer, NUM_STAGES=2:
  - Stimulus: UNSYNC_BUS=0xA5, raise REQ_ASYNC just before edge 0; drop REQ_ASYNC after ACK is seen.
  - Required: SYNC_BUS=0xA5 and ENABLE_PULSE=1 at edge 2 only; ACK=1 from edge 2; ACK=0 two edges after REQ_ASYNC is first sampled low.
- Back-to-back: three full handshakes with 0x01, 0x7E, 0xFF.
  - Required: exactly three single-cycle pulses, SYNC_BUS matching each value in order, spacing ≥4 cycles.
- Long REQ / data change: hold REQ_ASYNC high 50 cycles and change UNSYNC_BUS to 0x3C after ACK.
  - Required: one pulse only; SYNC_BUS keeps the first value.
- Glitch: a 1-cycle low dip on REQ_ASYNC during WAIT_LOW.
  - Required: no ACK drop and no extra pulse, provided the dip is not sampled by the last stage.
- Reset mid-transfer: assert RST during WAIT_LOW with REQ_ASYNC held high.
  - Required: all outputs 0 immediately. After release, recapture of the current UNSYNC_BUS at release+3 edges.
- NUM_STAGES=3 rerun of the basic transfer.
  - Required: capture and pulse at edge 3, ACK drop 3 edges after REQ_ASYNC is first sampled low.
